// File: rtl/jtag_dtm.sv
// JTAG Debug Transport Module: oversampled TAP controller with IDCODE, DTMCS,
// DMI and BYPASS data registers, acting as initiator on the DMI trivial bus.
module jtag_dtm #(
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter int          ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             dmi_start,
  input  logic             dmi_finish,
  output logic [1:0]       dmi_op,
  output logic [ABITS-1:0] dmi_address,
  output logic [31:0]      dmi_data_o,
  input  logic [31:0]      dmi_data_i
);

  localparam int DRW = ABITS + 34;

  typedef enum logic [3:0] {
    TAP_RESET, TAP_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;

  typedef enum logic [1:0] {DIDLE, DSTART, DWAIT} dmi_state_t;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_t;

  logic tck_s1, tck_s2, tck_q;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic tck_rise, tck_fall;

  tap_state_t tap_state, tap_next;
  logic       in_reset, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  logic [4:0]     ir, ir_sr;
  logic [DRW-1:0] dr;
  dr_sel_t        sel;
  logic [31:0]    dtmcs_value;

  dmi_state_t  dmi_state, dmi_next;
  logic [1:0]  dmistat;
  logic [31:0] result;
  logic        discard;
  logic        busy, finishing, busy_eff, launch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_s1 <= 1'b0; tck_s2 <= 1'b0; tck_q <= 1'b0;
      tms_s1 <= 1'b0; tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0; tdi_s2 <= 1'b0;
    end else begin
      tck_s1 <= tck;  tck_s2 <= tck_s1; tck_q <= tck_s2;
      tms_s1 <= tms;  tms_s2 <= tms_s1;
      tdi_s1 <= tdi;  tdi_s2 <= tdi_s1;
    end
  end

  assign tck_rise = tck_s2 & ~tck_q;
  assign tck_fall = ~tck_s2 & tck_q;

  always_ff @(posedge clk) begin
    if (!rst_n)        tap_state <= TAP_RESET;
    else if (tck_rise) tap_state <= tap_next;
  end

  always_comb begin
    tap_next = tap_state;
    unique case (tap_state)
      TAP_RESET:  tap_next = tms_s2 ? TAP_RESET : TAP_IDLE;
      TAP_IDLE:   tap_next = tms_s2 ? SELECT_DR : TAP_IDLE;
      SELECT_DR:  tap_next = tms_s2 ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: tap_next = tms_s2 ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   tap_next = tms_s2 ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   tap_next = tms_s2 ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   tap_next = tms_s2 ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   tap_next = tms_s2 ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  tap_next = tms_s2 ? SELECT_DR : TAP_IDLE;
      SELECT_IR:  tap_next = tms_s2 ? TAP_RESET : CAPTURE_IR;
      CAPTURE_IR: tap_next = tms_s2 ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   tap_next = tms_s2 ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   tap_next = tms_s2 ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   tap_next = tms_s2 ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   tap_next = tms_s2 ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  tap_next = tms_s2 ? SELECT_DR : TAP_IDLE;
    endcase
  end

  // Capture and shift act on the rise leaving the state; update acts on the fall inside it.
  always_comb begin
    in_reset = (tap_state == TAP_RESET);
    cap_dr   = tck_rise && (tap_state == CAPTURE_DR);
    sh_dr    = tck_rise && (tap_state == SHIFT_DR);
    upd_dr   = tck_fall && (tap_state == UPDATE_DR);
    cap_ir   = tck_rise && (tap_state == CAPTURE_IR);
    sh_ir    = tck_rise && (tap_state == SHIFT_IR);
    upd_ir   = tck_fall && (tap_state == UPDATE_IR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir    <= 5'h01;
      ir_sr <= 5'h00;
    end else begin
      if (cap_ir)     ir_sr <= 5'b00001;
      else if (sh_ir) ir_sr <= {tdi_s2, ir_sr[4:1]};
      if (in_reset)    ir <= 5'h01;
      else if (upd_ir) ir <= ir_sr;
    end
  end

  always_comb begin
    unique case (ir)
      5'h01:   sel = SEL_IDCODE;
      5'h10:   sel = SEL_DTMCS;
      5'h11:   sel = SEL_DMI;
      default: sel = SEL_BYPASS;
    endcase
  end

  assign dtmcs_value = {14'b0, 2'b0, 1'b0, IDLE_HINT, dmistat, 6'(ABITS), 4'd1};

  // A finish arriving on the same clk as an update or capture frees the bus first.
  assign busy      = (dmi_state != DIDLE);
  assign finishing = (dmi_state == DWAIT) && dmi_finish;
  assign busy_eff  = busy && !finishing;
  assign launch    = upd_dr && (sel == SEL_DMI) && (dmistat == 2'd0) && !busy_eff &&
                     ((dr[1:0] == 2'd1) || (dr[1:0] == 2'd2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dr <= '0;
    end else if (cap_dr) begin
      unique case (sel)
        SEL_IDCODE: dr <= {{(DRW-32){1'b0}}, IDCODE};
        SEL_DTMCS:  dr <= {{(DRW-32){1'b0}}, dtmcs_value};
        SEL_DMI:    dr <= busy_eff ? {dmi_address, dmi_data_o, 2'd3}
                                   : {dmi_address, result, dmistat};
        default:    dr <= '0;
      endcase
    end else if (sh_dr) begin
      unique case (sel)
        SEL_DMI:               dr <= {tdi_s2, dr[DRW-1:1]};
        SEL_IDCODE, SEL_DTMCS: dr <= {{(DRW-32){1'b0}}, tdi_s2, dr[31:1]};
        default:               dr <= {{(DRW-1){1'b0}}, tdi_s2};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdo <= 1'b0;
    end else if (tck_fall) begin
      if (tap_state == SHIFT_IR)      tdo <= ir_sr[0];
      else if (tap_state == SHIFT_DR) tdo <= dr[0];
      else                            tdo <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmistat     <= 2'd0;
      result      <= '0;
      discard     <= 1'b0;
      dmi_address <= '0;
      dmi_data_o  <= '0;
      dmi_op      <= 2'd0;
    end else begin
      if (finishing) begin
        if (!discard) result <= (dmi_op == 2'd1) ? dmi_data_i : dmi_data_o;
        discard <= 1'b0;
      end
      if (in_reset)
        dmistat <= 2'd0;
      else if ((cap_dr || upd_dr) && (sel == SEL_DMI) && busy_eff)
        dmistat <= 2'd3;
      else if (upd_dr && (sel == SEL_DTMCS) && (dr[16] || dr[17]))
        dmistat <= 2'd0;
      if (upd_dr && (sel == SEL_DTMCS) && dr[17] && busy_eff)
        discard <= 1'b1;
      if (launch) begin
        dmi_address <= dr[DRW-1:34];
        dmi_data_o  <= dr[33:2];
        dmi_op      <= dr[1:0];
        discard     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dmi_state <= DIDLE;
    else        dmi_state <= dmi_next;
  end

  always_comb begin
    dmi_next = dmi_state;
    unique case (dmi_state)
      DIDLE:   if (launch) dmi_next = DSTART;
      DSTART:  dmi_next = DWAIT;
      DWAIT:   if (dmi_finish) dmi_next = DIDLE;
      default: dmi_next = DIDLE;
    endcase
  end

  always_comb begin
    dmi_start = (dmi_state == DSTART);
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: drives JTAG scans through the oversampled pins
// and answers DMI requests with a simple debug-module model.
module tb_jtag_dtm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        dmi_start;
  logic        dmi_finish = 1'b0;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  int          dm_delay = 3;
  logic [31:0] dm_rdata = 32'h0;
  int          dm_cnt = 0;
  int          starts = 0;
  int          fins = 0;
  logic [6:0]  st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_op = '0;
  logic [6:0]  fin_addr = '0;
  logic [1:0]  fin_op = '0;

  jtag_dtm #(.IDCODE(32'h1000_0001), .ABITS(7), .IDLE_HINT(3'd1)) dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .dmi_start(dmi_start), .dmi_finish(dmi_finish), .dmi_op(dmi_op),
    .dmi_address(dmi_address), .dmi_data_o(dmi_data_o), .dmi_data_i(dmi_data_i)
  );

  always #5 clk = ~clk;

  // Debug-module model: answers each request after dm_delay clocks.
  always @(negedge clk) begin
    dmi_finish = 1'b0;
    if (dm_cnt > 0) begin
      dm_cnt--;
      if (dm_cnt == 0) begin
        dmi_finish = 1'b1;
        dmi_data_i = dm_rdata;
        fins++;
        fin_addr = dmi_address;
        fin_op   = dmi_op;
      end
    end
    if (dmi_start === 1'b1) begin
      starts++;
      st_addr = dmi_address;
      st_data = dmi_data_o;
      st_op   = dmi_op;
      dm_cnt  = dm_delay;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(negedge clk);
    tms = tms_v;
    tdi = tdi_v;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
    tdo_v = tdo;
  endtask

  task automatic go_reset_idle();
    logic b;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    dout[0] = b;
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, din[i], b);
      if (i < 4) dout[i+1] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic scan_dr(input int n, input logic [40:0] din, output logic [40:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    dout[0] = b;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      if (i < n - 1) dout[i+1] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tdo, dmi_start, dmi_op} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got tdo/start/op %b expected 0000", {tdo, dmi_start, dmi_op});
    end
    vectors++;
    if ({dmi_address, dmi_data_o} !== 39'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: got addr %h data %h expected 0 0", dmi_address, dmi_data_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idcode();
    logic [40:0] d;
    go_reset_idle();
    scan_dr(32, 41'h0, d);
    vectors++;
    if (d[31:0] !== 32'h1000_0001) begin
      miscompares++;
      $display("[TB] FAIL idcode: got %h expected 10000001", d[31:0]);
    end
    vectors++;
    if (starts !== 0) begin
      miscompares++;
      $display("[TB] FAIL idcode_no_start: got %0d starts expected 0", starts);
    end
  endtask

  task automatic test_dtmcs();
    logic [4:0]  irout;
    logic [40:0] d;
    scan_ir(5'h10, irout);
    vectors++;
    if (irout !== 5'b00001) begin
      miscompares++;
      $display("[TB] FAIL ir_capture: got %b expected 00001", irout);
    end
    scan_dr(32, 41'h0, d);
    vectors++;
    if (d[31:0] !== 32'h0000_1071) begin
      miscompares++;
      $display("[TB] FAIL dtmcs: got %h expected 00001071", d[31:0]);
    end
  endtask

  task automatic test_dmi_write();
    logic [4:0]  irout;
    logic [40:0] d;
    dm_delay = 3;
    scan_ir(5'h11, irout);
    scan_dr(41, {7'h10, 32'h1, 2'd2}, d);
    vectors++;
    if (starts !== 1 || st_addr !== 7'h10 || st_data !== 32'h1 || st_op !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL write_start: got n=%0d a=%h d=%h op=%0d expected n=1 a=10 d=1 op=2",
               starts, st_addr, st_data, st_op);
    end
    vectors++;
    if (fins !== 1 || fin_addr !== 7'h10 || fin_op !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL write_hold: got n=%0d a=%h op=%0d at finish expected n=1 a=10 op=2",
               fins, fin_addr, fin_op);
    end
    scan_dr(41, 41'h0, d);
    vectors++;
    if (d !== {7'h10, 32'h1, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL write_result: got %h expected %h", d, {7'h10, 32'h1, 2'd0});
    end
  endtask

  task automatic test_dmi_read();
    logic [40:0] d;
    dm_rdata = 32'h0003_0382;
    scan_dr(41, {7'h11, 32'h0, 2'd1}, d);
    vectors++;
    if (starts !== 2 || st_addr !== 7'h11 || st_op !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL read_start: got n=%0d a=%h op=%0d expected n=2 a=11 op=1",
               starts, st_addr, st_op);
    end
    scan_dr(41, 41'h0, d);
    vectors++;
    if (d !== {7'h11, 32'h0003_0382, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL read_result: got %h expected %h", d, {7'h11, 32'h0003_0382, 2'd0});
    end
  endtask

  task automatic test_busy();
    logic [4:0]  irout;
    logic [40:0] d;
    dm_delay = 200;
    scan_dr(41, {7'h12, 32'hDEAD_BEEF, 2'd2}, d);
    scan_dr(41, {7'h13, 32'h5, 2'd2}, d);
    vectors++;
    if (d !== {7'h12, 32'hDEAD_BEEF, 2'd3}) begin
      miscompares++;
      $display("[TB] FAIL busy_capture: got %h expected %h", d, {7'h12, 32'hDEAD_BEEF, 2'd3});
    end
    vectors++;
    if (starts !== 3) begin
      miscompares++;
      $display("[TB] FAIL busy_ignored: got %0d starts expected 3", starts);
    end
    scan_ir(5'h10, irout);
    scan_dr(32, 41'h0_0001_0000, d);
    vectors++;
    if (d[31:0] !== 32'h0000_1C71) begin
      miscompares++;
      $display("[TB] FAIL dtmcs_sticky: got %h expected 00001c71", d[31:0]);
    end
    scan_dr(32, 41'h0, d);
    vectors++;
    if (d[31:0] !== 32'h0000_1071) begin
      miscompares++;
      $display("[TB] FAIL dmireset: got %h expected 00001071", d[31:0]);
    end
    dm_delay = 3;
    scan_ir(5'h11, irout);
    scan_dr(41, {7'h14, 32'h7, 2'd2}, d);
    vectors++;
    if (d !== {7'h12, 32'hDEAD_BEEF, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL busy_result: got %h expected %h", d, {7'h12, 32'hDEAD_BEEF, 2'd0});
    end
    vectors++;
    if (starts !== 4 || st_addr !== 7'h14 || st_data !== 32'h7) begin
      miscompares++;
      $display("[TB] FAIL relaunch: got n=%0d a=%h d=%h expected n=4 a=14 d=7",
               starts, st_addr, st_data);
    end
  endtask

  task automatic test_bypass();
    logic [4:0]  irout;
    logic [40:0] d;
    scan_ir(5'h1f, irout);
    scan_dr(8, 41'hA5, d);
    vectors++;
    if (d[7:0] !== 8'h4A) begin
      miscompares++;
      $display("[TB] FAIL bypass: got %h expected 4a", d[7:0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [4:0]  irout;
    logic [40:0] d;
    int          f0;
    scan_ir(5'h11, irout);
    dm_rdata = 32'h1234_5678;
    dm_delay = 200;
    scan_dr(41, {7'h15, 32'h9, 2'd1}, d);
    vectors++;
    if (d !== {7'h14, 32'h7, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL prior_result: got %h expected %h", d, {7'h14, 32'h7, 2'd0});
    end
    vectors++;
    if (starts !== 5 || dmi_op !== 2'd1 || dmi_address !== 7'h15) begin
      miscompares++;
      $display("[TB] FAIL inflight: got n=%0d op=%0d a=%h expected n=5 op=1 a=15",
               starts, dmi_op, dmi_address);
    end
    f0 = fins;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({dmi_start, dmi_op, dmi_address, dmi_data_o} !== 42'h0) begin
      miscompares++;
      $display("[TB] FAIL midwait_reset: got start=%b op=%0d a=%h d=%h expected all 0",
               dmi_start, dmi_op, dmi_address, dmi_data_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 400 && fins == f0; i++) @(negedge clk);
    vectors++;
    if (fins !== f0 + 1) begin
      miscompares++;
      $display("[TB] FAIL late_finish_timeout: got %0d finishes expected %0d", fins, f0 + 1);
    end
    repeat (3) @(negedge clk);
    go_reset_idle();
    scan_dr(32, 41'h0, d);
    vectors++;
    if (d[31:0] !== 32'h1000_0001) begin
      miscompares++;
      $display("[TB] FAIL ir_after_reset: got %h expected 10000001", d[31:0]);
    end
    scan_ir(5'h11, irout);
    scan_dr(41, 41'h0, d);
    vectors++;
    if (d !== 41'h0) begin
      miscompares++;
      $display("[TB] FAIL late_finish_ignored: got %h expected 0", d);
    end
    vectors++;
    if (starts !== 5) begin
      miscompares++;
      $display("[TB] FAIL start_count: got %0d expected 5", starts);
    end
  endtask

  initial begin
    $display("[TB] jtag_dtm directed test");
    test_reset();
    test_idcode();
    test_dtmcs();
    test_dmi_write();
    test_dmi_read();
    test_busy();
    test_bypass();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
